// File: rtl/shift_arbiter_if.sv
// Request/result bundle for shift_arbiter: two requesters (A, B) feeding one
// shifter, plus a single-entry result channel with valid/ready handshake.
interface shift_arbiter_if;
  logic        a_valid;
  logic [15:0] a_data;
  logic [3:0]  a_shift;
  logic        a_dir;
  logic        a_ready;

  logic        b_valid;
  logic [15:0] b_data;
  logic [3:0]  b_shift;
  logic        b_dir;
  logic        b_ready;

  logic        res_valid;
  logic [15:0] res_data;
  logic        res_id;
  logic        res_ready;

  modport master (
    output a_valid, a_data, a_shift, a_dir,
    input  a_ready,
    output b_valid, b_data, b_shift, b_dir,
    input  b_ready,
    input  res_valid, res_data, res_id,
    output res_ready
  );

  modport slave (
    input  a_valid, a_data, a_shift, a_dir,
    output a_ready,
    input  b_valid, b_data, b_shift, b_dir,
    output b_ready,
    output res_valid, res_data, res_id,
    input  res_ready
  );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one 16-bit logical shifter between two requesters,
// with a single registered result slot that sustains one result per cycle.
module shift_arbiter #(
  parameter bit RESET_PRIO = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  shift_arbiter_if.slave  bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e      state_q, state_d;
  logic        prio_q, prio_d;
  logic [15:0] res_data_q, res_data_d;
  logic        res_id_q, res_id_d;

  logic        res_valid;
  logic        slot_free;
  logic        grant_a, grant_b;
  logic        accept_a, accept_b, accept;
  logic [15:0] sel_data, shifted;
  logic [3:0]  sel_shift;
  logic        sel_dir;

  // Grants depend only on the valids and the pointer, never on request payloads.
  always_comb begin
    grant_a = bus.a_valid & (~bus.b_valid | ~prio_q);
    grant_b = bus.b_valid & (~bus.a_valid |  prio_q);
  end

  assign slot_free   = ~res_valid | bus.res_ready;
  assign bus.a_ready = rst_n & grant_a & slot_free;
  assign bus.b_ready = rst_n & grant_b & slot_free;
  assign accept_a    = bus.a_valid & bus.a_ready;
  assign accept_b    = bus.b_valid & bus.b_ready;
  assign accept      = accept_a | accept_b;

  always_comb begin
    sel_data  = grant_b ? bus.b_data  : bus.a_data;
    sel_shift = grant_b ? bus.b_shift : bus.a_shift;
    sel_dir   = grant_b ? bus.b_dir   : bus.a_dir;
    shifted   = sel_dir ? (sel_data << sel_shift) : (sel_data >> sel_shift);
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // FSM: next-state logic
  always_comb begin
    // NOTE: default assignment first so no path through this block infers a latch.
    state_d = state_q;
    unique case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (!accept && bus.res_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // FSM: outputs
  always_comb begin
    res_valid = (state_q == FULL);
  end

  // Result payload and round-robin pointer
  always_comb begin
    res_data_d = res_data_q;
    res_id_d   = res_id_q;
    prio_d     = prio_q;
    if (accept) begin
      res_data_d = shifted;
      res_id_d   = accept_b;
      prio_d     = ~accept_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data_q <= 16'h0000;
      res_id_q   <= 1'b0;
      prio_q     <= RESET_PRIO;
    end else begin
      res_data_q <= res_data_d;
      res_id_q   <= res_id_d;
      prio_q     <= prio_d;
    end
  end

  assign bus.res_valid = res_valid;
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench: two arbiters (RESET_PRIO 0 and 1) on identical stimulus,
// compared every cycle against a behavioural model of grants, shifts and the result slot.
module tb_shift_arbiter;

  logic clk;
  logic rst_n;

  shift_arbiter_if u_if0 ();
  shift_arbiter_if u_if1 ();

  assign u_if1.a_valid   = u_if0.a_valid;
  assign u_if1.a_data    = u_if0.a_data;
  assign u_if1.a_shift   = u_if0.a_shift;
  assign u_if1.a_dir     = u_if0.a_dir;
  assign u_if1.b_valid   = u_if0.b_valid;
  assign u_if1.b_data    = u_if0.b_data;
  assign u_if1.b_shift   = u_if0.b_shift;
  assign u_if1.b_dir     = u_if0.b_dir;
  assign u_if1.res_ready = u_if0.res_ready;

  shift_arbiter #(.RESET_PRIO(1'b0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(u_if0.slave));
  shift_arbiter #(.RESET_PRIO(1'b1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(u_if1.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one entry per DUT, index = RESET_PRIO of that instance
  bit          m_full [2];
  logic [15:0] m_data [2];
  bit          m_id   [2];
  bit          m_prio [2];

  function automatic logic [15:0] shift_ref(input logic [15:0] d, input logic [3:0] s, input logic dir);
    int unsigned v, p;
    v = d;
    p = 1 << s;
    return dir ? 16'((v * p) % 65536) : 16'(v / p);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_full[i] = 0;
      m_data[i] = 16'h0000;
      m_id[i]   = 0;
      m_prio[i] = (i == 1);
    end
  endtask

  task automatic get_outs(input int i, output logic v, output logic [15:0] d, output logic id,
                          output logic ar, output logic br);
    if (i == 0) begin
      v = u_if0.res_valid; d = u_if0.res_data; id = u_if0.res_id; ar = u_if0.a_ready; br = u_if0.b_ready;
    end else begin
      v = u_if1.res_valid; d = u_if1.res_data; id = u_if1.res_id; ar = u_if1.a_ready; br = u_if1.b_ready;
    end
  endtask

  task automatic check_results();
    logic v, id, ar, br;
    logic [15:0] d;
    for (int i = 0; i < 2; i++) begin
      get_outs(i, v, d, id, ar, br);
      check($sformatf("res_valid[%0d]", i), 32'(v), 32'(m_full[i]));
      if (m_full[i]) begin
        check($sformatf("res_data[%0d]", i), 32'(d), 32'(m_data[i]));
        check($sformatf("res_id[%0d]", i), 32'(id), 32'(m_id[i]));
      end
    end
  endtask

  // Called just after a falling edge with inputs already driven: checks
  // readies, advances the model across the rising edge, checks results.
  task automatic cycle();
    logic v, id, ar, br;
    logic [15:0] d;
    bit slot, exp_a, exp_b;
    #1;
    for (int i = 0; i < 2; i++) begin
      get_outs(i, v, d, id, ar, br);
      slot  = !m_full[i] || u_if0.res_ready;
      if (u_if0.a_valid && u_if0.b_valid) begin
        exp_a = slot && (m_prio[i] == 0);
        exp_b = slot && (m_prio[i] == 1);
      end else begin
        exp_a = slot && u_if0.a_valid;
        exp_b = slot && u_if0.b_valid;
      end
      check($sformatf("a_ready[%0d]", i), 32'(ar), 32'(exp_a));
      check($sformatf("b_ready[%0d]", i), 32'(br), 32'(exp_b));
      check($sformatf("one_ready[%0d]", i), 32'(ar & br), 32'(0));
      if (exp_a) begin
        m_data[i] = shift_ref(u_if0.a_data, u_if0.a_shift, u_if0.a_dir);
        m_id[i] = 0; m_full[i] = 1; m_prio[i] = 1;
      end else if (exp_b) begin
        m_data[i] = shift_ref(u_if0.b_data, u_if0.b_shift, u_if0.b_dir);
        m_id[i] = 1; m_full[i] = 1; m_prio[i] = 0;
      end else if (u_if0.res_ready) begin
        m_full[i] = 0;
      end
    end
    @(negedge clk);
    check_results();
  endtask

  task automatic drive_a(input bit v, input logic [15:0] d, input logic [3:0] s, input bit dir);
    u_if0.a_valid = v; u_if0.a_data = d; u_if0.a_shift = s; u_if0.a_dir = dir;
  endtask

  task automatic drive_b(input bit v, input logic [15:0] d, input logic [3:0] s, input bit dir);
    u_if0.b_valid = v; u_if0.b_data = d; u_if0.b_shift = s; u_if0.b_dir = dir;
  endtask

  // Asynchronous reset pulse placed between edges; ends at the next falling edge.
  task automatic mid_reset();
    logic v, id, ar, br;
    logic [15:0] d;
    drive_a(1, 16'hFFFF, 4'd1, 1);
    drive_b(1, 16'hFFFF, 4'd1, 0);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      get_outs(i, v, d, id, ar, br);
      check($sformatf("rst_valid[%0d]", i), 32'(v), 32'(0));
      check($sformatf("rst_data[%0d]", i), 32'(d), 32'(0));
      check($sformatf("rst_id[%0d]", i), 32'(id), 32'(0));
      check($sformatf("rst_a_ready[%0d]", i), 32'(ar), 32'(0));
      check($sformatf("rst_b_ready[%0d]", i), 32'(br), 32'(0));
    end
    model_reset();
    drive_a(0, 16'h0, 4'd0, 0);
    drive_b(0, 16'h0, 4'd0, 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_results();
  endtask

  initial begin
    rst_n = 1'b0;
    drive_a(0, 16'h0, 4'd0, 0);
    drive_b(0, 16'h0, 4'd0, 0);
    u_if0.res_ready = 1'b0;
    model_reset();

    // Reset state, then release and go straight into the first transaction
    #3;
    check_results();
    check("reset_data0", 32'(u_if0.res_data), 32'h0);
    check("reset_ready_a0", 32'(u_if0.a_ready), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // A only: 0x00F0 << 4
    drive_a(1, 16'h00F0, 4'd4, 1);
    u_if0.res_ready = 1'b1;
    cycle();
    check("a_only_data", 32'(u_if0.res_data), 32'h0F00);
    check("a_only_id", 32'(u_if0.res_id), 32'(0));

    // B only: 0x8001 >> 15, then shift 0
    drive_a(0, 16'h1234, 4'd3, 0);
    drive_b(1, 16'h8001, 4'd15, 0);
    cycle();
    check("b_only_data", 32'(u_if0.res_data), 32'h0001);
    check("b_only_id", 32'(u_if0.res_id), 32'(1));
    drive_b(1, 16'h8001, 4'd0, 0);
    cycle();
    check("b_shift0_data", 32'(u_if0.res_data), 32'h8001);
    drive_b(0, 16'h0, 4'd0, 0);
    cycle();

    // Both valid from reset: alternating ids starting at each RESET_PRIO
    mid_reset();
    drive_a(1, 16'h0001, 4'd1, 1);
    drive_b(1, 16'h0100, 4'd1, 0);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check($sformatf("rr_id0_%0d", k), 32'(u_if0.res_id), 32'(k % 2));
      check($sformatf("rr_id1_%0d", k), 32'(u_if1.res_id), 32'((k + 1) % 2));
      check($sformatf("rr_valid_%0d", k), 32'(u_if0.res_valid), 32'(1));
    end

    // Backpressure: result held three cycles, then drained while A is accepted
    drive_b(0, 16'h0, 4'd0, 0);
    drive_a(1, 16'hA5A5, 4'd2, 1);
    cycle();
    u_if0.res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_a(1, 16'(k * 16'h1111), 4'(k), 0);
      cycle();
      check($sformatf("hold_data_%0d", k), 32'(u_if0.res_data), 32'h9694);
    end
    u_if0.res_ready = 1'b1;
    drive_a(1, 16'h0F0F, 4'd4, 0);
    cycle();
    check("release_data", 32'(u_if0.res_data), 32'h00F0);

    // Mid-cycle reset while FULL, then check both pointers return to reset value
    mid_reset();
    drive_a(1, 16'h0003, 4'd0, 1);
    drive_b(1, 16'h0005, 4'd0, 1);
    cycle();
    check("post_rst_id0", 32'(u_if0.res_id), 32'(0));
    check("post_rst_id1", 32'(u_if1.res_id), 32'(1));

    // Randomised traffic, inputs scrambled even while not valid
    for (int n = 0; n < 2000; n++) begin
      drive_a($urandom_range(0, 3) != 0, 16'($urandom), 4'($urandom), 1'($urandom));
      drive_b($urandom_range(0, 3) != 0, 16'($urandom), 4'($urandom), 1'($urandom));
      u_if0.res_ready = $urandom_range(0, 3) != 0;
      if (n % 500 == 499) mid_reset();
      else                cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 SHALL have parameter: RESET_PRIO, 0, requester favoured by the first arbitration after reset (0 = A, 1 = B).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: a_valid  input  1; a_data  input  16; a_shift  input  4; a_dir  input  1 -- requester A (dir 1 = left, 0 = right).
REQ-005 SHALL have port: a_ready  output  1  requester A accepted this cycle.
REQ-006 SHALL have ports: b_valid, b_data, b_shift, b_dir, b_ready -- requester B, same widths and meanings as A.
REQ-007 SHALL have port: res_valid  output  1  result register holds an undelivered result.
REQ-008 SHALL have port: res_data  output  16  shifted result.
REQ-009 SHALL have port: res_id  output  1  source of result (0 = A, 1 = B).
REQ-010 SHALL have port: res_ready  input  1  consumer accepts the result.

Function
REQ-011 SHALL share one 16-bit logical shifter between A and B: dir=1 gives data << shift, dir=0 gives data >> shift, vacated bits zero, shift=0 passes data unchanged.
REQ-012 SHALL define slot_free = !res_valid | res_ready (combinational).
REQ-013 SHALL use a one-bit round-robin pointer prio; when both valid, the prio requester is granted.
REQ-014 SHALL grant a lone valid requester regardless of prio.
REQ-015 SHALL drive x_ready = grant_x & slot_free, combinational, at most one ready high per cycle; ready SHALL NOT depend on the ungranted requester's data.
REQ-016 SHALL accept (handshake) when x_valid & x_ready; on that edge load res_data with the shifted value, res_id with the source, and set res_valid -- latency exactly 1 cycle.
REQ-017 SHALL, after an accept from X, set prio to the other requester; prio SHALL be unchanged in cycles without an accept.
REQ-018 SHALL operate as a two-state machine: EMPTY (res_valid=0) and FULL (res_valid=1).
REQ-019 SHALL transition EMPTY->FULL on accept; FULL->EMPTY on res_ready with no accept; FULL->FULL with the new result on simultaneous res_ready and accept (full throughput, one result per cycle).
REQ-020 SHALL hold res_data and res_id stable while res_valid=1 and res_ready=0.
REQ-021 SHALL ignore res_ready while EMPTY.
REQ-022 SHALL tolerate requester inputs changing while x_valid=0 and SHALL NOT require x_valid to be held.

Reset
REQ-023 SHALL, on rst_n low, immediately clear res_valid=0, res_data=16'h0000, res_id=0, prio=RESET_PRIO, independent of clk.
REQ-024 SHALL force a_ready=b_ready=0 while rst_n is low.
REQ-025 SHALL discard a held, undelivered result if reset asserts mid-operation; no result reappears after release.
REQ-026 SHALL allow the first accept on the first rising clk edge after rst_n deasserts.

Verification
REQ-027 SHALL cover: A only, a_data=16'h00F0, a_shift=4, a_dir=1, res_ready=1 -> next cycle res_valid=1, res_data=16'h0F00, res_id=0.
REQ-028 SHALL cover: B only, b_data=16'h8001, b_shift=15, b_dir=0 -> res_data=16'h0001, res_id=1; with shift=0 -> res_data=16'h8001.
REQ-029 SHALL cover: A and B valid continuously, res_ready=1, RESET_PRIO=0 -> res_id sequence 0,1,0,1, one result per cycle, never two readies high.
REQ-030 SHALL cover: res_ready=0 for 3 cycles with A valid -> res_valid stays 1, res_data stable, a_ready=0; res_ready=1 -> A accepted the same cycle, new result next cycle.
REQ-031 SHALL cover: rst_n pulsed low between clock edges while FULL -> res_valid, res_data, res_id drop to 0 without a clock edge; prio returns to RESET_PRIO.
REQ-032 SHALL cover: RESET_PRIO=1, both valid on first cycle after reset -> B granted first (res_id=1).
